// File: rtl/lfsr_bist_ctrl_pkg.sv
// Shared definitions for the LFSR BIST sequencer: state encoding, LFSR geometry,
// default seed and the x^4 + x^3 + 1 step function used by both the LFSR and the MISR.
package lfsr_bist_ctrl_pkg;

    localparam int unsigned LFSR_W = 4;
    localparam int unsigned TAP_HI = 3;
    localparam int unsigned TAP_LO = 2;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_bist_ctrl_lfsr4_core.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1) with synchronous load and step enable.
// Load has priority over enable so a run restart always begins from the seed.
module lfsr4_core
    import lfsr_bist_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer: streams PAT_CNT LFSR patterns, compacts responses into a MISR and
// checks the signature. Optional response watchdog enabled by `define BIST_TIMEOUT_EN.
module lfsr_bist_ctrl
    import lfsr_bist_ctrl_pkg::*;
#(
    parameter int unsigned       PAT_CNT = 15,
    parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED,
    parameter int unsigned       TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              sync_rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] exp_sig,
    output logic              pat_valid,
    input  logic              pat_ready,
    output logic [LFSR_W-1:0] pat_data,
    input  logic              resp_valid,
    input  logic [LFSR_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout
);

    localparam logic [3:0] NUM_PAT  = 4'(PAT_CNT);
    localparam logic [3:0] LAST_PAT = 4'(PAT_CNT - 1);

    if (PAT_CNT < 1 || PAT_CNT > 15 || SEED == '0 || TIMEOUT < 1) begin : g_cfg_err
        $error("lfsr_bist_ctrl: unsupported PAT_CNT/SEED/TIMEOUT");
    end

    bist_state_e       state_q, state_d;
    logic [LFSR_W-1:0] misr_q, misr_d;
    logic [3:0]        issue_cnt_q, issue_cnt_d;
    logic [3:0]        resp_cnt_q, resp_cnt_d;
    logic              pass_q, pass_d;
    logic              start_go, pat_hs, resp_acc;

`ifdef BIST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    assign start_go = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign pat_hs   = (state_q == ST_RUN) && pat_ready;
    assign resp_acc = resp_valid && (state_q == ST_RUN || state_q == ST_DRAIN)
                      && (resp_cnt_q < NUM_PAT);

    // Reload on sync reset too, so the LFSR follows the same priority as the rest.
    lfsr4_core #(
        .RST_VAL (SEED)
    ) u_pat_lfsr (
        .clk       (clk),
        .async_rst (async_rst),
        .en_i      (pat_hs),
        .load_i    (sync_rst || start_go),
        .seed_i    (SEED),
        .state_o   (pat_data)
    );

    always_comb begin
        state_d     = state_q;
        misr_d      = misr_q;
        issue_cnt_d = issue_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        pass_d      = pass_q;
        pat_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
`ifdef BIST_TIMEOUT_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif

        if (resp_acc) begin
            misr_d     = lfsr_step(misr_q) ^ resp_in;
            resp_cnt_d = resp_cnt_q + 4'd1;
        end
        if (pat_hs) begin
            issue_cnt_d = issue_cnt_q + 4'd1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start_go) begin
                    state_d     = ST_RUN;
                    misr_d      = '0;
                    issue_cnt_d = '0;
                    resp_cnt_d  = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_RUN: begin
                pat_valid = 1'b1;
                busy      = 1'b1;
                if (pat_hs && issue_cnt_q == LAST_PAT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (resp_cnt_q == NUM_PAT) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy    = 1'b1;
                pass_d  = (misr_q == exp_sig);
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BIST_TIMEOUT_EN
        // A completed drain wins over a watchdog expiring in the same cycle.
        if (state_q == ST_RUN || state_q == ST_DRAIN) begin
            if (resp_acc) begin
                wd_d = '0;
            end else if (wd_q == WD_LAST && state_d != ST_CHECK) begin
                state_d   = ST_DONE;
                timeout_d = 1'b1;
                pass_d    = 1'b0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
        if (start_go) begin
            wd_d      = '0;
            timeout_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q     <= ST_IDLE;
            misr_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            pass_q      <= 1'b0;
        end else if (sync_rst) begin
            state_q     <= ST_IDLE;
            misr_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            misr_q      <= misr_d;
            issue_cnt_q <= issue_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            pass_q      <= pass_d;
        end
    end

`ifdef BIST_TIMEOUT_EN
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (sync_rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign pass = pass_q;

endmodule
